// File: rtl/dec_n_scan.sv
// Registered N-to-2**N decoder that holds a loaded select or auto-scans.
// Optional thermometer output mode: define DEC_SCAN_THERMO_EN to add port TM.
module dec_n_scan #(
    parameter int N     = 2,
    parameter int DWELL = 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           E,
    input  logic           LD,
    input  logic [N-1:0]   S,
    input  logic           SCAN,
`ifdef DEC_SCAN_THERMO_EN
    input  logic           TM,
`endif
    output logic [2**N-1:0] O,
    output logic           BUSY,
    output logic           WRAP
);

    localparam int W  = 2 ** N;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [N-1:0]  SEL_LAST = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_SCAN
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  sel;
    logic [N-1:0]  sel_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          wrap_nxt;
    logic [W-1:0]  onehot;
    logic [W-1:0]  code;
    logic [W-1:0]  o_nxt;

    // Next state, select and dwell counter; LD beats SCAN, RST is in the register.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        cnt_nxt   = cnt;
        wrap_nxt  = 1'b0;
        if (LD) begin
            sel_nxt   = S;
            cnt_nxt   = '0;
            state_nxt = ST_HOLD;
        end else begin
            unique case (state)
                ST_IDLE, ST_HOLD: begin
                    if (SCAN) begin
                        state_nxt = ST_SCAN;
                        cnt_nxt   = '0;
                    end
                end
                ST_SCAN: begin
                    if (!SCAN) begin
                        state_nxt = ST_HOLD;
                        cnt_nxt   = '0;
                    end else if (E) begin
                        if (cnt == CNT_LAST) begin
                            cnt_nxt  = '0;
                            sel_nxt  = sel + 1'b1;
                            wrap_nxt = (sel == SEL_LAST);
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Decode the next select; the thermometer is onehot*2-1 modulo 2**W,
    // which also yields all ones for the top code.
    always_comb begin
        onehot = W'(1) << sel_nxt;
        code   = onehot;
`ifdef DEC_SCAN_THERMO_EN
        if (TM) begin
            code = (onehot << 1) - W'(1);
        end
`endif
        o_nxt = (E && (state_nxt != ST_IDLE)) ? code : '0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            sel   <= '0;
            cnt   <= '0;
            O     <= '0;
            BUSY  <= 1'b0;
            WRAP  <= 1'b0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            cnt   <= cnt_nxt;
            O     <= o_nxt;
            BUSY  <= (state_nxt == ST_SCAN);
            WRAP  <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_dec_n_scan.sv
// Scoreboard bench for dec_n_scan: two instances (N=2/DWELL=3, N=1/DWELL=1)
// share stimulus; a reference model predicts O/BUSY/WRAP every cycle.
module tb_dec_n_scan;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       E = 1'b0;
    logic       LD = 1'b0;
    logic [1:0] S = 2'd0;
    logic       SCAN = 1'b0;
    logic       TM = 1'b0;

    logic [3:0] o0;
    logic       busy0, wrap0;
    logic [1:0] o1;
    logic       busy1, wrap1;

    always #5 CLK = ~CLK;

    dec_n_scan #(.N(2), .DWELL(3)) u0 (
        .CLK(CLK), .RST(RST), .E(E), .LD(LD), .S(S), .SCAN(SCAN),
`ifdef DEC_SCAN_THERMO_EN
        .TM(TM),
`endif
        .O(o0), .BUSY(busy0), .WRAP(wrap0)
    );

    dec_n_scan #(.N(1), .DWELL(1)) u1 (
        .CLK(CLK), .RST(RST), .E(E), .LD(LD), .S(S[0]), .SCAN(SCAN),
`ifdef DEC_SCAN_THERMO_EN
        .TM(TM),
`endif
        .O(o1), .BUSY(busy1), .WRAP(wrap1)
    );

    typedef struct {
        int o0; int b0; int w0;
        int o1; int b1; int w1;
    } exp_t;

    exp_t q[$];
    int nvec = 0;
    int nmis = 0;

    // Reference model: mode 0=idle 1=hold 2=scan; outputs are a pure
    // function of the model after each clock.
    int nn[2] = '{2, 1};
    int dw[2] = '{3, 1};
    int m_mode[2];
    int m_sel[2];
    int m_cnt[2];
    int m_wrap[2];
    int m_o[2];

    function automatic void model_step(int k, bit rst, bit e, bit ld,
                                       int s, bit scan, bit tm);
        int size;
        size = 1 << nn[k];
        m_wrap[k] = 0;
        if (rst) begin
            m_mode[k] = 0; m_sel[k] = 0; m_cnt[k] = 0;
        end else if (ld) begin
            m_sel[k] = s % size; m_cnt[k] = 0; m_mode[k] = 1;
        end else if (m_mode[k] != 2 && scan) begin
            m_mode[k] = 2; m_cnt[k] = 0;
        end else if (m_mode[k] == 2 && !scan) begin
            m_mode[k] = 1; m_cnt[k] = 0;
        end else if (m_mode[k] == 2 && e) begin
            m_cnt[k]++;
            if (m_cnt[k] == dw[k]) begin
                m_cnt[k] = 0;
                if (m_sel[k] == size - 1) m_wrap[k] = 1;
                m_sel[k] = (m_sel[k] + 1) % size;
            end
        end
        m_o[k] = 0;
        if (!rst && e && m_mode[k] != 0) begin
            m_o[k] = 1 << m_sel[k];
`ifdef DEC_SCAN_THERMO_EN
            if (tm) m_o[k] = (1 << (m_sel[k] + 1)) - 1;
`endif
        end
    endfunction

    task automatic cyc(bit rst, bit e, bit ld, int s, bit scan, bit tm);
        exp_t x;
        @(negedge CLK);
        RST = rst; E = e; LD = ld; S = 2'(s); SCAN = scan; TM = tm;
        model_step(0, rst, e, ld, s, scan, tm);
        model_step(1, rst, e, ld, s, scan, tm);
        x.o0 = m_o[0]; x.b0 = (m_mode[0] == 2); x.w0 = m_wrap[0];
        x.o1 = m_o[1]; x.b1 = (m_mode[1] == 2); x.w1 = m_wrap[1];
        q.push_back(x);
    endtask

    task automatic chk(string name, int act, int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    // Monitor: one registered result per clock.
    initial begin
        exp_t x;
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() != 0) begin
                x = q.pop_front();
                chk("o_n2",    int'(o0),    x.o0);
                chk("busy_n2", int'(busy0), x.b0);
                chk("wrap_n2", int'(wrap0), x.w0);
                chk("o_n1",    int'(o1),    x.o1);
                chk("busy_n1", int'(busy1), x.b1);
                chk("wrap_n1", int'(wrap1), x.w1);
            end
        end
    end

    initial begin
        bit scan_lvl;
        bit tm_lvl;
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_sel[k] = 0; m_cnt[k] = 0;
            m_wrap[k] = 0; m_o[k] = 0;
        end
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, 2, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 3, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) cyc(0, 1, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 1, 0);
        cyc(0, 1, 1, 1, 1, 0);
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 1, 0);
        cyc(1, 1, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, 2, 0, 1);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 1);
        scan_lvl = 1'b0;
        tm_lvl   = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) scan_lvl = ~scan_lvl;
            if ($urandom_range(0, 29) == 0) tm_lvl = ~tm_lvl;
            cyc($urandom_range(0, 59) == 0,
                $urandom_range(0, 7) != 0,
                $urandom_range(0, 24) == 0,
                int'($urandom_range(0, 3)),
                scan_lvl, tm_lvl);
        end
        @(posedge CLK);
        #2;
        nvec++;
        if (q.size() != 0) begin
            nmis++;
            $display("FAIL drain: %0d results pending, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
